// File: rtl/decode_stage_buf.sv
// -----------------------------------------------------------------------------
// decode_stage_buf
//
// Registered MIPS decode stage between fetch and execute, with a valid/ready
// handshake on both sides and a two-entry skid buffer (head H, skid S).
//
// Every decoded field is a flop. The fields are decoded when an entry is
// loaded into H, so nothing on Inst reaches an output combinationally.
// InReady is driven only by the registered skid-valid bit.
//
// Optional feature:
//   DECODE_CLASS_EN - when defined, adds the instClass output. It is a one-hot
//                     {J,I,R} instruction class that is registered with H.
//
// Parameters:
//   PC_WIDTH       width of PcPlus4 / PcPlus4Out / jumpTarget (28..32)
//   IMM_EXT_WIDTH  width of immExt (>= 16)
//
// Ports:
//   Clk, Reset       clock and synchronous active-high reset
//   Flush            drop every held entry; overrides accept and pop
//   InValid/InReady  upstream handshake (Inst, PcPlus4)
//   OutValid/OutReady downstream handshake for the head entry
//   opcode, Funct, shamt, rd, rt, rs, imm
//                    raw instruction fields of the head entry
//   immExt           zero-extended for andi/ori/xori, otherwise sign-extended
//   jumpTarget       {PcPlus4[top:28], Inst[25:0], 2'b00}
//   PcPlus4Out       PcPlus4 carried with the head entry
//   instClass        (DECODE_CLASS_EN only) one-hot {J,I,R}
// -----------------------------------------------------------------------------
module decode_stage_buf #(
  parameter int PC_WIDTH      = 32,
  parameter int IMM_EXT_WIDTH = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Flush,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [31:0]              Inst,
  input  logic [PC_WIDTH-1:0]      PcPlus4,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [5:0]               opcode,
  output logic [5:0]               Funct,
  output logic [4:0]               shamt,
  output logic [4:0]               rd,
  output logic [4:0]               rt,
  output logic [4:0]               rs,
  output logic [15:0]              imm,
  output logic [IMM_EXT_WIDTH-1:0] immExt,
  output logic [PC_WIDTH-1:0]      jumpTarget,
  output logic [PC_WIDTH-1:0]      PcPlus4Out
`ifdef DECODE_CLASS_EN
  ,
  output logic [2:0]               instClass
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                     h_valid_q, h_valid_d;
  logic                     s_valid_q, s_valid_d;
  logic [31:0]              s_inst_q, s_inst_d;
  logic [PC_WIDTH-1:0]      s_pc_q, s_pc_d;

  logic [5:0]               opcode_q, opcode_d;
  logic [5:0]               funct_q, funct_d;
  logic [4:0]               shamt_q, shamt_d;
  logic [4:0]               rd_q, rd_d;
  logic [4:0]               rt_q, rt_d;
  logic [4:0]               rs_q, rs_d;
  logic [15:0]              imm_q, imm_d;
  logic [IMM_EXT_WIDTH-1:0] imm_ext_q, imm_ext_d;
  logic [PC_WIDTH-1:0]      jump_target_q, jump_target_d;
  logic [PC_WIDTH-1:0]      pc_plus4_q, pc_plus4_d;
`ifdef DECODE_CLASS_EN
  logic [2:0]               inst_class_q, inst_class_d;
`endif

  // ---------------------------------------------------------------------------
  // Handshake and transfer control
  // ---------------------------------------------------------------------------
  logic accept;
  logic pop;
  logic load_h;       // H takes a new entry this cycle
  logic h_from_skid;  // that entry comes from S rather than from the input

  assign accept = InValid & InReady;
  assign pop    = h_valid_q & OutReady;

  always_comb begin
    h_valid_d   = h_valid_q;
    s_valid_d   = s_valid_q;
    s_inst_d    = s_inst_q;
    s_pc_d      = s_pc_q;
    load_h      = 1'b0;
    h_from_skid = 1'b0;

    if (Flush) begin
      // Flush wins over both pop and accept. The field registers keep their
      // values; only the valid bits are cleared.
      h_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (pop && !accept) begin
      if (s_valid_q) begin
        load_h      = 1'b1;
        h_from_skid = 1'b1;
        s_valid_d   = 1'b0;
      end else begin
        h_valid_d = 1'b0;
      end
    end else if (accept && (!h_valid_q || pop)) begin
      // When H pops and accepts in the same cycle, S is known to be empty,
      // because InReady would otherwise be low.
      load_h    = 1'b1;
      h_valid_d = 1'b1;
    end else if (accept) begin
      // H is holding and not draining, so the new entry parks in S.
      s_valid_d = 1'b1;
      s_inst_d  = Inst;
      s_pc_d    = PcPlus4;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode of the entry that is being loaded into H
  // ---------------------------------------------------------------------------
  logic [31:0]              src_inst;
  logic [PC_WIDTH-1:0]      src_pc;
  logic [5:0]               src_opcode;
  logic                     src_zero_ext;
  logic                     imm_fill;
  logic [IMM_EXT_WIDTH-1:0] dec_imm_ext;
  logic [PC_WIDTH-1:0]      dec_jump_target;

  assign src_inst   = h_from_skid ? s_inst_q : Inst;
  assign src_pc     = h_from_skid ? s_pc_q   : PcPlus4;
  assign src_opcode = src_inst[31:26];

  // andi / ori / xori use a zero-extended immediate. Every other opcode
  // sign-extends from imm[15].
  assign src_zero_ext = (src_opcode == 6'h0C) || (src_opcode == 6'h0D) ||
                        (src_opcode == 6'h0E);
  assign imm_fill     = src_inst[15] & ~src_zero_ext;

  assign dec_imm_ext[15:0] = src_inst[15:0];
  for (genvar gi = 16; gi < IMM_EXT_WIDTH; gi++) begin : g_imm_fill
    assign dec_imm_ext[gi] = imm_fill;
  end

  // The jump target stays inside the current 256 MiB region. PcPlus4 bits
  // above 28 are copied as they are, and no carry is formed into them.
  assign dec_jump_target[27:0] = {src_inst[25:0], 2'b00};
  for (genvar gi = 28; gi < PC_WIDTH; gi++) begin : g_jump_region
    assign dec_jump_target[gi] = src_pc[gi];
  end

  always_comb begin
    opcode_d      = opcode_q;
    funct_d       = funct_q;
    shamt_d       = shamt_q;
    rd_d          = rd_q;
    rt_d          = rt_q;
    rs_d          = rs_q;
    imm_d         = imm_q;
    imm_ext_d     = imm_ext_q;
    jump_target_d = jump_target_q;
    pc_plus4_d    = pc_plus4_q;
    if (load_h) begin
      opcode_d      = src_opcode;
      funct_d       = src_inst[5:0];
      shamt_d       = src_inst[10:6];
      rd_d          = src_inst[15:11];
      rt_d          = src_inst[20:16];
      rs_d          = src_inst[25:21];
      imm_d         = src_inst[15:0];
      imm_ext_d     = dec_imm_ext;
      jump_target_d = dec_jump_target;
      pc_plus4_d    = src_pc;
    end
  end

`ifdef DECODE_CLASS_EN
  // One-hot {J,I,R}: R for SPECIAL (0x00), J for j/jal, I for everything else.
  always_comb begin
    inst_class_d = inst_class_q;
    if (load_h) begin
      if (src_opcode == 6'h00) begin
        inst_class_d = 3'b001;
      end else if ((src_opcode == 6'h02) || (src_opcode == 6'h03)) begin
        inst_class_d = 3'b100;
      end else begin
        inst_class_d = 3'b010;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      h_valid_q     <= 1'b0;
      s_valid_q     <= 1'b0;
      s_inst_q      <= '0;
      s_pc_q        <= '0;
      opcode_q      <= '0;
      funct_q       <= '0;
      shamt_q       <= '0;
      rd_q          <= '0;
      rt_q          <= '0;
      rs_q          <= '0;
      imm_q         <= '0;
      imm_ext_q     <= '0;
      jump_target_q <= '0;
      pc_plus4_q    <= '0;
    end else begin
      h_valid_q     <= h_valid_d;
      s_valid_q     <= s_valid_d;
      s_inst_q      <= s_inst_d;
      s_pc_q        <= s_pc_d;
      opcode_q      <= opcode_d;
      funct_q       <= funct_d;
      shamt_q       <= shamt_d;
      rd_q          <= rd_d;
      rt_q          <= rt_d;
      rs_q          <= rs_d;
      imm_q         <= imm_d;
      imm_ext_q     <= imm_ext_d;
      jump_target_q <= jump_target_d;
      pc_plus4_q    <= pc_plus4_d;
    end
  end

`ifdef DECODE_CLASS_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      inst_class_q <= 3'b000;
    end else begin
      inst_class_q <= inst_class_d;
    end
  end

  assign instClass = inst_class_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign InReady    = ~s_valid_q;
  assign OutValid   = h_valid_q;
  assign opcode     = opcode_q;
  assign Funct      = funct_q;
  assign shamt      = shamt_q;
  assign rd         = rd_q;
  assign rt         = rt_q;
  assign rs         = rs_q;
  assign imm        = imm_q;
  assign immExt     = imm_ext_q;
  assign jumpTarget = jump_target_q;
  assign PcPlus4Out = pc_plus4_q;

endmodule

// File: tb/tb_decode_stage_buf.sv
// Testbench for decode_stage_buf. Directed scenarios use expected values taken
// from the instruction encodings. A randomized run is then checked against a
// queue-based model of the two-entry buffer.
module tb_decode_stage_buf;

  logic        Clk = 1'b0;
  logic        Reset, Flush, InValid, InReady, OutValid, OutReady;
  logic [31:0] Inst, PcPlus4;
  logic [5:0]  opcode, Funct;
  logic [4:0]  shamt, rd, rt, rs;
  logic [15:0] imm;
  logic [31:0] immExt, jumpTarget, PcPlus4Out;
`ifdef DECODE_CLASS_EN
  logic [2:0]  instClass;
`endif

  always #5 Clk = ~Clk;

  decode_stage_buf #(.PC_WIDTH(32), .IMM_EXT_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .Inst(Inst), .PcPlus4(PcPlus4), .OutValid(OutValid), .OutReady(OutReady),
    .opcode(opcode), .Funct(Funct), .shamt(shamt), .rd(rd), .rt(rt), .rs(rs),
    .imm(imm), .immExt(immExt), .jumpTarget(jumpTarget), .PcPlus4Out(PcPlus4Out)
`ifdef DECODE_CLASS_EN
    , .instClass(instClass)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: an ordered queue of held entries. The front of the queue
  // is the head entry, and the queue holds at most two entries.
  typedef struct packed { logic [31:0] inst; logic [31:0] pc; } entry_t;
  entry_t model_q[$];
  entry_t last_head;
  logic   have_head;

  function automatic logic [31:0] ref_imm_ext(input logic [31:0] i);
    int op  = int'(i[31:26]);
    int val = int'(i[15:0]);
    if (!(op >= 12 && op <= 14) && val >= 32768) val = val - 65536;
    return 32'(val);
  endfunction

  function automatic logic [31:0] ref_jump(input logic [31:0] i, input logic [31:0] pc);
    return (pc & 32'hF000_0000) | ((i & 32'h03FF_FFFF) << 2);
  endfunction

  function automatic logic [2:0] ref_class(input logic [31:0] i);
    int op = int'(i[31:26]);
    if (op == 0) return 3'b001;
    if (op == 2 || op == 3) return 3'b100;
    return 3'b010;
  endfunction

  // Drives one cycle of inputs, advances the model at the clock edge, and
  // returns 1 time unit after the edge.
  task automatic step(input logic inv, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic rst);
    logic   acc, pp;
    entry_t e;
    InValid = inv; Inst = inst; PcPlus4 = pc; OutReady = ordy; Flush = fl; Reset = rst;
    @(posedge Clk);
    acc = inv && (model_q.size() < 2);
    pp  = (model_q.size() > 0) && ordy;
    e.inst = inst; e.pc = pc;
    if (rst) begin
      model_q.delete(); have_head = 1'b0;
    end else if (fl) begin
      model_q.delete();
    end else begin
      if (pp) void'(model_q.pop_front());
      if (acc) model_q.push_back(e);
    end
    if (!rst && model_q.size() > 0) begin last_head = model_q[0]; have_head = 1'b1; end
    #1;
  endtask

  task automatic test_reset();
    step(0, 32'h0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 32'h0, 0, 0, 1);
    n_checks++; if (OutValid !== 1'b0) $display("FAIL reset_outvalid got=%0b exp=0", OutValid); else n_pass++;
    n_checks++; if (InReady !== 1'b1) $display("FAIL reset_inready got=%0b exp=1", InReady); else n_pass++;
    n_checks++; if ({opcode, Funct, shamt, rd, rt, rs, imm} !== 48'h0) $display("FAIL reset_fields got=%h exp=0", {opcode, Funct, shamt, rd, rt, rs, imm}); else n_pass++;
    n_checks++; if ({immExt, jumpTarget, PcPlus4Out} !== 96'h0) $display("FAIL reset_ext_pc got=%h exp=0", {immExt, jumpTarget, PcPlus4Out}); else n_pass++;
`ifdef DECODE_CLASS_EN
    n_checks++; if (instClass !== 3'b000) $display("FAIL reset_class got=%b exp=000", instClass); else n_pass++;
`endif
    $display("reset: OutValid=%0b InReady=%0b", OutValid, InReady);
  endtask

  task automatic test_r_type();
    step(1, 32'h012A_4020, 32'h0040_0004, 1, 0, 0);
    n_checks++; if (OutValid !== 1'b1) $display("FAIL rtype_valid got=%0b exp=1", OutValid); else n_pass++;
    n_checks++; if (opcode !== 6'd0) $display("FAIL rtype_opcode got=%0d exp=0", opcode); else n_pass++;
    n_checks++; if (rs !== 5'd9) $display("FAIL rtype_rs got=%0d exp=9", rs); else n_pass++;
    n_checks++; if (rt !== 5'd10) $display("FAIL rtype_rt got=%0d exp=10", rt); else n_pass++;
    n_checks++; if (rd !== 5'd8) $display("FAIL rtype_rd got=%0d exp=8", rd); else n_pass++;
    n_checks++; if (shamt !== 5'd0) $display("FAIL rtype_shamt got=%0d exp=0", shamt); else n_pass++;
    n_checks++; if (Funct !== 6'h20) $display("FAIL rtype_funct got=%h exp=20", Funct); else n_pass++;
    n_checks++; if (PcPlus4Out !== 32'h0040_0004) $display("FAIL rtype_pc got=%h exp=00400004", PcPlus4Out); else n_pass++;
`ifdef DECODE_CLASS_EN
    n_checks++; if (instClass !== 3'b001) $display("FAIL class_add got=%b exp=001", instClass); else n_pass++;
`endif
    $display("r_type: add accepted, rs=%0d rt=%0d rd=%0d", rs, rt, rd);
  endtask

  task automatic test_imm_ext();
    step(1, 32'h2108_FFFF, 32'h0040_0008, 1, 0, 0);
    n_checks++; if (immExt !== 32'hFFFF_FFFF) $display("FAIL addi_immext got=%h exp=ffffffff", immExt); else n_pass++;
    step(1, 32'h3508_FFFF, 32'h0040_000C, 1, 0, 0);
    n_checks++; if (immExt !== 32'h0000_FFFF) $display("FAIL ori_immext got=%h exp=0000ffff", immExt); else n_pass++;
    step(1, 32'h8D08_FFFC, 32'h0040_0010, 1, 0, 0);
    n_checks++; if (immExt !== 32'hFFFF_FFFC) $display("FAIL lw_immext got=%h exp=fffffffc", immExt); else n_pass++;
`ifdef DECODE_CLASS_EN
    n_checks++; if (instClass !== 3'b010) $display("FAIL class_lw got=%b exp=010", instClass); else n_pass++;
`endif
    $display("imm_ext: lw immExt=%h", immExt);
  endtask

  task automatic test_jump();
    step(1, 32'h0800_0010, 32'h4000_0004, 1, 0, 0);
    n_checks++; if (jumpTarget !== 32'h4000_0040) $display("FAIL jump_target got=%h exp=40000040", jumpTarget); else n_pass++;
`ifdef DECODE_CLASS_EN
    n_checks++; if (instClass !== 3'b100) $display("FAIL class_j got=%b exp=100", instClass); else n_pass++;
`endif
    step(0, 32'h0, 32'h0, 1, 0, 0);
    n_checks++; if (OutValid !== 1'b0) $display("FAIL drain_valid got=%0b exp=0", OutValid); else n_pass++;
    n_checks++; if (jumpTarget !== 32'h4000_0040) $display("FAIL hold_fields got=%h exp=40000040", jumpTarget); else n_pass++;
    $display("jump: jumpTarget=%h", jumpTarget);
  endtask

  task automatic test_back_to_back();
    step(1, 32'h0109_5020, 32'h0000_1004, 0, 0, 0);
    n_checks++; if (OutValid !== 1'b1 || InReady !== 1'b1) $display("FAIL b2b_a got=%0b%0b exp=11", OutValid, InReady); else n_pass++;
    step(1, 32'h2129_0001, 32'h0000_1008, 0, 0, 0);
    n_checks++; if (InReady !== 1'b0) $display("FAIL b2b_full got=%0b exp=0", InReady); else n_pass++;
    step(1, 32'h3C0A_1234, 32'h0000_100C, 0, 0, 0);
    n_checks++; if (InReady !== 1'b0 || PcPlus4Out !== 32'h0000_1004) $display("FAIL b2b_stall got=%0b/%h exp=0/00001004", InReady, PcPlus4Out); else n_pass++;
    step(1, 32'h3C0A_1234, 32'h0000_100C, 1, 0, 0);
    n_checks++; if (OutValid !== 1'b1 || PcPlus4Out !== 32'h0000_1008) $display("FAIL b2b_pop_b got=%0b/%h exp=1/00001008", OutValid, PcPlus4Out); else n_pass++;
    n_checks++; if (InReady !== 1'b1) $display("FAIL b2b_ready got=%0b exp=1", InReady); else n_pass++;
    step(1, 32'h3C0A_1234, 32'h0000_100C, 1, 0, 0);
    n_checks++; if (OutValid !== 1'b1 || PcPlus4Out !== 32'h0000_100C || imm !== 16'h1234) $display("FAIL b2b_pop_c got=%0b/%h/%h exp=1/0000100c/1234", OutValid, PcPlus4Out, imm); else n_pass++;
    step(0, 32'h0, 32'h0, 1, 0, 0);
    n_checks++; if (OutValid !== 1'b0) $display("FAIL b2b_empty got=%0b exp=0", OutValid); else n_pass++;
    $display("back_to_back: A,B,C popped in order");
  endtask

  task automatic test_flush();
    step(1, 32'h0109_5020, 32'h0000_2004, 0, 0, 0);
    step(1, 32'h2129_0001, 32'h0000_2008, 0, 0, 0);
    step(1, 32'h3C0A_5555, 32'h0000_200C, 0, 1, 0);
    n_checks++; if (OutValid !== 1'b0 || InReady !== 1'b1) $display("FAIL flush_state got=%0b%0b exp=01", OutValid, InReady); else n_pass++;
    step(0, 32'h0, 32'h0, 1, 0, 0);
    n_checks++; if (OutValid !== 1'b0 || PcPlus4Out !== 32'h0000_2004) $display("FAIL flush_discard got=%0b/%h exp=0/00002004", OutValid, PcPlus4Out); else n_pass++;
    $display("flush: OutValid=%0b InReady=%0b", OutValid, InReady);
  endtask

  task automatic test_reset_midstream();
    step(1, 32'h0109_5020, 32'h0000_3004, 0, 0, 0);
    step(1, 32'h2129_0001, 32'h0000_3008, 0, 0, 0);
    step(1, 32'h2129_0002, 32'h0000_300C, 1, 0, 1);
    n_checks++; if (OutValid !== 1'b0 || InReady !== 1'b1) $display("FAIL midrst_state got=%0b%0b exp=01", OutValid, InReady); else n_pass++;
    n_checks++; if ({opcode, rs, imm, immExt, jumpTarget, PcPlus4Out} !== 123'h0) $display("FAIL midrst_fields got=%h exp=0", {opcode, rs, imm, immExt, jumpTarget, PcPlus4Out}); else n_pass++;
    $display("reset_midstream: OutValid=%0b InReady=%0b", OutValid, InReady);
  endtask

  task automatic test_random();
    logic [5:0]  op_tab [11] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h0F};
    logic [31:0] inst, pc, ei;
    logic [127:0] exp_f, got_f;
    int errs = 0;
    for (int n = 0; n < 400; n++) begin
      inst = $urandom;
      if ($urandom_range(0, 1) == 1) inst[31:26] = op_tab[$urandom_range(0, 10)];
      pc = $urandom;
      step(($urandom_range(0, 9) < 7), inst, pc, ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
      ei = have_head ? last_head.inst : 32'h0;
      exp_f = have_head ? {ei[31:0], ref_imm_ext(ei), ref_jump(ei, last_head.pc), last_head.pc} : 128'h0;
      got_f = {opcode, rs, rt, rd, shamt, Funct, immExt, jumpTarget, PcPlus4Out};
      n_checks++; if (OutValid !== (model_q.size() > 0)) begin errs++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", n, OutValid, model_q.size() > 0); end else n_pass++;
      n_checks++; if (InReady !== (model_q.size() < 2)) begin errs++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", n, InReady, model_q.size() < 2); end else n_pass++;
      n_checks++; if (got_f !== exp_f || imm !== ei[15:0]) begin errs++; $display("FAIL rand_fields cyc=%0d got=%h exp=%h", n, got_f, exp_f); end else n_pass++;
`ifdef DECODE_CLASS_EN
      n_checks++; if (instClass !== (have_head ? ref_class(ei) : 3'b000)) begin errs++; $display("FAIL rand_class cyc=%0d got=%b", n, instClass); end else n_pass++;
`endif
    end
    $display("random: 400 cycles, %0d mismatching comparisons", errs);
  endtask

  initial begin
    have_head = 1'b0;
    last_head = '0;
    test_reset();
    test_r_type();
    test_imm_ext();
    test_jump();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
